// File: rtl/sccb_cfg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sccb_cfg_pkg
// Brief    : Shared types and constants for the SCCB configuration sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package sccb_cfg_pkg;

  // Script entry opcodes
  typedef enum logic [1:0] {
    OP_WRITE      = 2'b00,
    OP_READ_CHECK = 2'b01,
    OP_DELAY      = 2'b10,
    OP_END        = 2'b11
  } op_e;

  // Widest supported register address; narrower REG_AW values are
  // zero-extended into this field when an entry is unpacked.
  localparam int REG_AW_MAX = 16;

  typedef struct packed {
    op_e                   op;
    logic [REG_AW_MAX-1:0] regaddr;
    logic [7:0]            data;
    logic [7:0]            mask;
  } entry_t;

  // Error codes reported on o_err_code
  localparam logic [1:0] c_err_none     = 2'b00;
  localparam logic [1:0] c_err_nack     = 2'b01;
  localparam logic [1:0] c_err_mismatch = 2'b10;
  localparam logic [1:0] c_err_overrun  = 2'b11;

  // Sequencer states
  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_FETCH  = 4'd1,
    ST_DECODE = 4'd2,
    ST_REQ    = 4'd3,
    ST_XFER   = 4'd4,
    ST_WAIT   = 4'd5,
    ST_NEXT   = 4'd6,
    ST_DONE   = 4'd7,
    ST_ERROR  = 4'd8
  } state_e;

  // Read-verify: only the bits selected by mask take part in the compare
  function automatic logic check_pass(input logic [7:0] rdata,
                                      input logic [7:0] data,
                                      input logic [7:0] mask);
    return ((rdata & mask) == (data & mask));
  endfunction

endpackage
`default_nettype wire

// File: rtl/sccb_delay_timer.sv
`default_nettype none
// ============================================================================
// Module   : sccb_delay_timer
// Brief    : Unit-count delay timer. A load captures the unit count, a
//            prescaler divides clk into units, and o_expire pulses once when
//            the count has run out (one cycle after load for a zero count).
// Revision : 1.0 - initial release
// ============================================================================
module sccb_delay_timer #(
  parameter int CNT_W    = 16,
  parameter int UNIT_CYC = 50000
) (
  input  logic             clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_count,
  output logic             o_expire
);

  localparam int PRESC_W = (UNIT_CYC > 1) ? $clog2(UNIT_CYC) : 1;
  localparam logic [PRESC_W-1:0] c_presc_last = PRESC_W'(UNIT_CYC - 1);

  logic [CNT_W-1:0]   r_units;
  logic [PRESC_W-1:0] r_presc;
  logic               r_active;

  // Unit counter only decrements while non-zero, so it can never wrap
  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_units  <= '0;
      r_presc  <= '0;
      r_active <= 1'b0;
    end else if (i_load) begin
      r_units  <= i_count;
      r_presc  <= '0;
      r_active <= 1'b1;
    end else if (r_active) begin
      if (r_units == '0) begin
        r_active <= 1'b0;
      end else if (r_presc == c_presc_last) begin
        r_presc <= '0;
        r_units <= r_units - 1'b1;
      end else begin
        r_presc <= r_presc + 1'b1;
      end
    end
  end

  assign o_expire = r_active && (r_units == '0);

endmodule
`default_nettype wire

// File: rtl/sccb_cfg_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : sccb_cfg_sequencer
// Brief    : Script-driven SCCB/I2C register configuration sequencer. Fetches
//            entries from a synchronous ROM and issues writes, read-verifies
//            and delays through a byte-level I2C master handshake.
// Revision : 1.0 - initial release
// ============================================================================
module sccb_cfg_sequencer
  import sccb_cfg_pkg::*;
#(
  parameter int         CLK_HZ         = 50000000,
  parameter int         REG_AW         = 16,
  parameter int         SCRIPT_DEPTH   = 128,
  parameter logic [6:0] DEV_ADDR       = 7'h60,
  parameter int         MAX_RETRY      = 3,
  parameter int         DELAY_UNIT_CYC = CLK_HZ / 1000,
  localparam int        AW             = $clog2(SCRIPT_DEPTH),
  localparam int        ENTRY_W        = 2 + REG_AW + 16
) (
  input  logic               clk,
  input  logic               i_rst,
  input  logic               i_start,
  output logic [AW-1:0]      o_rom_addr,
  input  logic [ENTRY_W-1:0] i_rom_data,
  output logic               o_i2c_req,
  input  logic               i_i2c_ready,
  output logic               o_i2c_rw,
  output logic [6:0]         o_i2c_dev,
  output logic [REG_AW-1:0]  o_i2c_reg,
  output logic [7:0]         o_i2c_wdata,
  input  logic               i_i2c_done,
  input  logic               i_i2c_nack,
  input  logic [7:0]         i_i2c_rdata,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_error,
  output logic [1:0]         o_err_code,
  output logic [AW-1:0]      o_err_index
);

  localparam int            RETRY_W    = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [AW-1:0] c_idx_last = AW'(SCRIPT_DEPTH - 1);

  state_e               r_state, w_next;
  entry_t               r_entry, w_rom_entry;
  logic [AW-1:0]        r_idx;
  logic [RETRY_W-1:0]   r_retry;
  logic                 r_done, r_error;
  logic [1:0]           r_err_code;
  logic [AW-1:0]        r_err_index;

  logic                 w_ld_entry, w_tmr_load, w_tmr_expire;
  logic                 w_retry_inc, w_retry_clr, w_idx_inc, w_idx_clr;
  logic                 w_set_err, w_set_done, w_clr_status;
  logic [1:0]           w_err_code;
  logic                 w_pass;

  // Unpack the ROM word into the package entry layout (regaddr zero-extended)
  always_comb begin
    w_rom_entry                      = '0;
    w_rom_entry.op                   = op_e'(i_rom_data[ENTRY_W-1 -: 2]);
    w_rom_entry.regaddr[REG_AW-1:0]  = i_rom_data[16 +: REG_AW];
    w_rom_entry.data                 = i_rom_data[15:8];
    w_rom_entry.mask                 = i_rom_data[7:0];
  end

  assign w_pass = check_pass(i_i2c_rdata, r_entry.data, r_entry.mask);

  sccb_delay_timer #(
    .CNT_W    (REG_AW),
    .UNIT_CYC (DELAY_UNIT_CYC)
  ) u_delay_timer (
    .clk      (clk),
    .i_rst    (i_rst),
    .i_load   (w_tmr_load),
    .i_count  (w_rom_entry.regaddr[REG_AW-1:0]),
    .o_expire (w_tmr_expire)
  );

  // State register
  always_ff @(posedge clk) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Next-state decode and datapath control strobes
  always_comb begin
    w_next       = r_state;
    o_i2c_req    = 1'b0;
    o_busy       = 1'b1;
    w_ld_entry   = 1'b0;
    w_tmr_load   = 1'b0;
    w_retry_inc  = 1'b0;
    w_retry_clr  = 1'b0;
    w_idx_inc    = 1'b0;
    w_idx_clr    = 1'b0;
    w_set_err    = 1'b0;
    w_err_code   = c_err_none;
    w_set_done   = 1'b0;
    w_clr_status = 1'b0;
    case (r_state)
      ST_IDLE: begin
        o_busy = 1'b0;
        if (i_start) begin
          w_idx_clr   = 1'b1;
          w_retry_clr = 1'b1;
          w_next      = ST_FETCH;
        end
      end
      ST_FETCH:  w_next = ST_DECODE;
      ST_DECODE: begin
        w_ld_entry = 1'b1;
        case (w_rom_entry.op)
          OP_WRITE, OP_READ_CHECK: w_next = ST_REQ;
          OP_DELAY: begin
            w_tmr_load = 1'b1;
            w_next     = ST_WAIT;
          end
          default: begin
            w_set_done = 1'b1;
            w_next     = ST_DONE;
          end
        endcase
      end
      ST_REQ: begin
        o_i2c_req = 1'b1;
        if (i_i2c_ready) w_next = ST_XFER;
      end
      ST_XFER: begin
        if (i_i2c_done) begin
          if (i_i2c_nack) begin
            if (r_retry < RETRY_W'(MAX_RETRY)) begin
              w_retry_inc = 1'b1;
              w_next      = ST_REQ;
            end else begin
              w_set_err  = 1'b1;
              w_err_code = c_err_nack;
              w_next     = ST_ERROR;
            end
          end else if ((r_entry.op == OP_READ_CHECK) && !w_pass) begin
            w_set_err  = 1'b1;
            w_err_code = c_err_mismatch;
            w_next     = ST_ERROR;
          end else begin
            w_next = ST_NEXT;
          end
        end
      end
      ST_WAIT: begin
        if (w_tmr_expire) w_next = ST_NEXT;
      end
      ST_NEXT: begin
        w_retry_clr = 1'b1;
        if (r_idx == c_idx_last) begin
          w_set_err  = 1'b1;
          w_err_code = c_err_overrun;
          w_next     = ST_ERROR;
        end else begin
          w_idx_inc = 1'b1;
          w_next    = ST_FETCH;
        end
      end
      ST_DONE, ST_ERROR: begin
        o_busy = 1'b0;
        if (i_start) begin
          w_clr_status = 1'b1;
          w_idx_clr    = 1'b1;
          w_retry_clr  = 1'b1;
          w_next       = ST_FETCH;
        end
      end
      default: begin
        o_busy = 1'b0;
        w_next = ST_IDLE;
      end
    endcase
  end

  // Script index, retry count, latched entry and status registers
  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_idx       <= '0;
      r_retry     <= '0;
      r_entry     <= '0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_err_code  <= c_err_none;
      r_err_index <= '0;
    end else begin
      if (w_idx_clr)      r_idx <= '0;
      else if (w_idx_inc) r_idx <= r_idx + 1'b1;

      if (w_retry_clr)      r_retry <= '0;
      else if (w_retry_inc) r_retry <= r_retry + 1'b1;

      if (w_ld_entry) r_entry <= w_rom_entry;

      if (w_clr_status) begin
        r_done      <= 1'b0;
        r_error     <= 1'b0;
        r_err_code  <= c_err_none;
        r_err_index <= '0;
      end else if (w_set_err) begin
        r_error     <= 1'b1;
        r_err_code  <= w_err_code;
        r_err_index <= r_idx;
      end else if (w_set_done) begin
        r_done <= 1'b1;
      end
    end
  end

  assign o_rom_addr  = r_idx;
  assign o_i2c_rw    = (r_entry.op == OP_READ_CHECK);
  assign o_i2c_dev   = DEV_ADDR;
  assign o_i2c_reg   = r_entry.regaddr[REG_AW-1:0];
  assign o_i2c_wdata = r_entry.data;
  assign o_done      = r_done;
  assign o_error     = r_error;
  assign o_err_code  = r_err_code;
  assign o_err_index = r_err_index;

endmodule
`default_nettype wire

// File: tb/tb_sccb_cfg_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_sccb_cfg_sequencer
// Brief    : Directed self-checking bench for sccb_cfg_sequencer with a
//            behavioural script ROM and byte-level I2C master.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sccb_cfg_sequencer;

  localparam int AW = 2;
  localparam int EW = 34;

  logic            clk = 1'b0;
  logic            i_rst = 1'b1;
  logic            i_start = 1'b0;
  logic [AW-1:0]   o_rom_addr;
  logic [EW-1:0]   rom_q = '0;
  logic            o_i2c_req;
  logic            i_i2c_ready = 1'b0;
  logic            o_i2c_rw;
  logic [6:0]      o_i2c_dev;
  logic [15:0]     o_i2c_reg;
  logic [7:0]      o_i2c_wdata;
  logic            i_i2c_done = 1'b0;
  logic            i_i2c_nack = 1'b0;
  logic [7:0]      i_i2c_rdata = '0;
  logic            o_busy, o_done, o_error;
  logic [1:0]      o_err_code;
  logic [AW-1:0]   o_err_index;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int t_start = 0;

  logic [EW-1:0] rom [0:3];

  // master model state and request log
  logic        m_ready_en = 1'b1;
  int          m_lat = 5;
  logic        m_pend = 1'b0;
  int          m_cnt = 0;
  int          m_idx = 0;
  int          req_n = 0;
  int          plan_base = 0;
  logic        nack_plan  [0:15];
  logic [7:0]  rdata_plan [0:15];
  logic [15:0] log_reg    [0:63];
  logic [7:0]  log_wdata  [0:63];
  logic        log_rw     [0:63];
  int          log_cyc    [0:63];

  sccb_cfg_sequencer #(
    .CLK_HZ         (10000),
    .REG_AW         (16),
    .SCRIPT_DEPTH   (4),
    .DEV_ADDR       (7'h60),
    .MAX_RETRY      (3),
    .DELAY_UNIT_CYC (10)
  ) dut (
    .clk         (clk),
    .i_rst       (i_rst),
    .i_start     (i_start),
    .o_rom_addr  (o_rom_addr),
    .i_rom_data  (rom_q),
    .o_i2c_req   (o_i2c_req),
    .i_i2c_ready (i_i2c_ready),
    .o_i2c_rw    (o_i2c_rw),
    .o_i2c_dev   (o_i2c_dev),
    .o_i2c_reg   (o_i2c_reg),
    .o_i2c_wdata (o_i2c_wdata),
    .i_i2c_done  (i_i2c_done),
    .i_i2c_nack  (i_i2c_nack),
    .i_i2c_rdata (i_i2c_rdata),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_error     (o_error),
    .o_err_code  (o_err_code),
    .o_err_index (o_err_index)
  );

  always #5 clk = ~clk;

  // cycle counter and synchronous script ROM (data valid one cycle after addr)
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rom_q <= rom[o_rom_addr];
  end

  // I2C master: accepts a request on the negedge, completes m_lat negedges later
  always @(negedge clk) begin
    i_i2c_done  = 1'b0;
    i_i2c_ready = 1'b0;
    if (m_pend) begin
      if (m_cnt <= 1) begin
        i_i2c_done  = 1'b1;
        i_i2c_nack  = nack_plan[m_idx[3:0]];
        i_i2c_rdata = rdata_plan[m_idx[3:0]];
        m_pend      = 1'b0;
      end else begin
        m_cnt = m_cnt - 1;
      end
    end
    if (!m_pend && !i_i2c_done && o_i2c_req && m_ready_en && !i_rst) begin
      i_i2c_ready       = 1'b1;
      log_reg[req_n]    = o_i2c_reg;
      log_wdata[req_n]  = o_i2c_wdata;
      log_rw[req_n]     = o_i2c_rw;
      log_cyc[req_n]    = cyc;
      m_idx             = req_n - plan_base;
      req_n             = req_n + 1;
      m_pend            = 1'b1;
      m_cnt             = m_lat;
    end
  end

  function automatic logic [EW-1:0] ent(input logic [1:0] op, input logic [15:0] r,
                                        input logic [7:0] d, input logic [7:0] m);
    return {op, r, d, m};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic new_plan();
    for (int i = 0; i < 16; i++) begin
      nack_plan[i]  = 1'b0;
      rdata_plan[i] = 8'h00;
    end
    plan_base = req_n;
  endtask

  task automatic start_pulse();
    @(negedge clk);
    i_start = 1'b1;
    t_start = cyc;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic run_to_idle(input string tag, input int budget);
    int n;
    n = 0;
    start_pulse();
    chk({tag, "_busy"}, o_busy, 1);
    while (o_busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_timeout"}, o_busy, 0);
  endtask

  initial begin
    int base;
    int gap0;
    int gap2;
    int n;
    for (int i = 0; i < 4; i++) rom[i] = ent(2'b11, 16'h0, 8'h0, 8'h0);
    new_plan();

    // ---- reset state
    repeat (3) @(negedge clk);
    chk("rst_flags", {o_busy, o_done, o_error, o_i2c_req, o_i2c_rw}, 0);
    chk("rst_dev", o_i2c_dev, 7'h60);
    chk("rst_code", {o_err_code, o_err_index, o_rom_addr}, 0);
    chk("rst_fields", {o_i2c_reg, o_i2c_wdata}, 0);
    i_rst = 1'b0;
    @(negedge clk);

    // ---- two writes then END
    rom[0] = ent(2'b00, 16'h0103, 8'h01, 8'h00);
    rom[1] = ent(2'b00, 16'h3039, 8'h32, 8'h00);
    rom[2] = ent(2'b11, 16'h0000, 8'h00, 8'h00);
    new_plan();
    base = req_n;
    run_to_idle("wr2", 300);
    chk("wr2_nreq", req_n - base, 2);
    chk("wr2_req0", {log_rw[base], log_reg[base], log_wdata[base]}, {1'b0, 16'h0103, 8'h01});
    chk("wr2_req1", {log_rw[base+1], log_reg[base+1], log_wdata[base+1]}, {1'b0, 16'h3039, 8'h32});
    chk("wr2_status", {o_done, o_error, o_err_code}, 4'b1000);

    // ---- read-check pass then mismatch
    rom[0] = ent(2'b01, 16'h300A, 8'h92, 8'hFF);
    rom[1] = ent(2'b01, 16'h300B, 8'h81, 8'hFF);
    rom[2] = ent(2'b11, 16'h0000, 8'h00, 8'h00);
    new_plan();
    rdata_plan[0] = 8'h92;
    rdata_plan[1] = 8'h80;
    base = req_n;
    run_to_idle("rc", 300);
    chk("rc_nreq", req_n - base, 2);
    chk("rc_rw", {log_rw[base], log_rw[base+1], log_reg[base+1]}, {2'b11, 16'h300B});
    chk("rc_status", {o_done, o_error, o_err_code}, 4'b0110);
    chk("rc_index", o_err_index, 1);

    // ---- NACK three times then ack
    rom[0] = ent(2'b00, 16'h0100, 8'h01, 8'h00);
    rom[1] = ent(2'b11, 16'h0000, 8'h00, 8'h00);
    new_plan();
    nack_plan[0] = 1'b1; nack_plan[1] = 1'b1; nack_plan[2] = 1'b1;
    base = req_n;
    run_to_idle("nack3", 400);
    chk("nack3_nreq", req_n - base, 4);
    chk("nack3_reg3", log_reg[base+3], 16'h0100);
    chk("nack3_status", {o_done, o_error, o_err_code}, 4'b1000);

    // ---- NACK four times -> error
    new_plan();
    for (int i = 0; i < 4; i++) nack_plan[i] = 1'b1;
    base = req_n;
    run_to_idle("nack4", 400);
    chk("nack4_nreq", req_n - base, 4);
    chk("nack4_status", {o_done, o_error, o_err_code}, 4'b0101);
    chk("nack4_index", o_err_index, 0);

    // ---- zero delay: no stall
    rom[0] = ent(2'b10, 16'h0000, 8'h00, 8'h00);
    rom[1] = ent(2'b00, 16'h3500, 8'h0A, 8'h00);
    rom[2] = ent(2'b11, 16'h0000, 8'h00, 8'h00);
    new_plan();
    base = req_n;
    run_to_idle("dly0", 300);
    chk("dly0_nreq", req_n - base, 1);
    gap0 = log_cyc[base] - t_start;
    chk("dly0_gap_small", (gap0 >= 5 && gap0 <= 12), 1);

    // ---- delay of 2 units at 10 cycles per unit
    rom[0] = ent(2'b10, 16'h0002, 8'h00, 8'h00);
    new_plan();
    base = req_n;
    run_to_idle("dly2", 300);
    chk("dly2_req", {req_n - base, 16'(log_reg[base])}, {32'd1, 16'h3500});
    gap2 = log_cyc[base] - t_start;
    chk("dly2_gap_min", (gap2 >= 22), 1);
    chk("dly2_gap_max", (gap2 <= 40), 1);
    chk("dly2_gap_delta", ((gap2 - gap0) >= 20), 1);

    // ---- no END in a 4-entry script -> overrun
    for (int i = 0; i < 4; i++) rom[i] = ent(2'b00, 16'h4000 + 16'(i), 8'(i), 8'h00);
    new_plan();
    base = req_n;
    run_to_idle("ovr", 600);
    chk("ovr_nreq", req_n - base, 4);
    chk("ovr_last_reg", log_reg[base+3], 16'h4003);
    chk("ovr_status", {o_done, o_error, o_err_code}, 4'b0111);
    chk("ovr_index", o_err_index, 3);

    // ---- restart after error runs from entry 0
    rom[0] = ent(2'b00, 16'h1111, 8'h22, 8'h00);
    rom[1] = ent(2'b11, 16'h0000, 8'h00, 8'h00);
    new_plan();
    base = req_n;
    run_to_idle("rst0", 300);
    chk("rst0_req", {req_n - base, 16'(log_reg[base])}, {32'd1, 16'h1111});
    chk("rst0_status", {o_done, o_error, o_err_code}, 4'b1000);

    // ---- ready held low keeps request and fields stable
    rom[0] = ent(2'b00, 16'h0103, 8'h5A, 8'h00);
    rom[1] = ent(2'b11, 16'h0000, 8'h00, 8'h00);
    new_plan();
    m_ready_en = 1'b0;
    base = req_n;
    start_pulse();
    repeat (8) @(negedge clk);
    chk("hold_a", {o_i2c_req, o_busy, o_i2c_rw, o_i2c_reg, o_i2c_wdata}, {3'b110, 16'h0103, 8'h5A});
    repeat (6) @(negedge clk);
    chk("hold_b", {o_i2c_req, o_busy, o_i2c_rw, o_i2c_reg, o_i2c_wdata}, {3'b110, 16'h0103, 8'h5A});

    // ---- reset during XFER
    m_lat = 20;
    m_ready_en = 1'b1;
    n = 0;
    while (req_n == base && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("xrst_accept", req_n - base, 1);
    repeat (2) @(negedge clk);
    i_rst = 1'b1;
    @(negedge clk);
    chk("xrst_flags", {o_busy, o_done, o_error, o_i2c_req, o_i2c_rw}, 0);
    chk("xrst_fields", {o_i2c_reg, o_i2c_wdata, o_err_code, o_rom_addr}, 0);
    chk("xrst_dev", o_i2c_dev, 7'h60);
    i_rst = 1'b0;
    repeat (25) @(negedge clk);
    chk("xrst_late_done", {o_busy, o_done, o_error, o_i2c_req}, 0);
    m_lat = 5;
    rom[0] = ent(2'b00, 16'h2222, 8'h11, 8'h00);
    new_plan();
    base = req_n;
    run_to_idle("after", 300);
    chk("after_req", {req_n - base, 16'(log_reg[base])}, {32'd1, 16'h2222});
    chk("after_status", {o_done, o_error}, 2'b10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
